// File: rtl/fpr_wr_arbiter.sv
// rtl/fpr_wr_arbiter.sv - round-robin write-port arbiter for the floating-point register file
//
// Purpose: owns the single FPR write port. Arbitrates between the load-return
// path (ld) and the FPU result path (fpu), and splits double-precision results
// into two 32-bit writes to an even/odd register pair. regWr/Rw/busW come
// straight from flops so they are settled well before the file's negedge write.
//
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   ld_valid/ld_ready/ld_addr/ld_dbl/ld_data       load-return request channel
//   fpu_valid/fpu_ready/fpu_addr/fpu_dbl/fpu_data  FPU result request channel
//   regWr, Rw, busW                   register-file write enable, index, data
//   busy                              a write sequence is in progress
module fpr_wr_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [ADDR_W-1:0]   ld_addr,
  input  logic                ld_dbl,
  input  logic [2*DATA_W-1:0] ld_data,
  input  logic                fpu_valid,
  output logic                fpu_ready,
  input  logic [ADDR_W-1:0]   fpu_addr,
  input  logic                fpu_dbl,
  input  logic [2*DATA_W-1:0] fpu_data,
  output logic                regWr,
  output logic [ADDR_W-1:0]   Rw,
  output logic [DATA_W-1:0]   busW,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR_A = 2'd1,
    WR_B = 2'd2
  } state_t;

  state_t              state;
  // Set once ld has been granted, so fpu wins the next tie; reset favours ld.
  logic                favour_fpu;
  // Second half of a double, held while the first word is on the bus.
  logic [DATA_W-1:0]   pend_lo;
  logic [ADDR_W-2:0]   pend_pair;
  logic                pend_dbl;

  logic                grant_ld;
  logic                grant_fpu;
  logic                accept;
  logic [ADDR_W-1:0]   sel_addr;
  logic                sel_dbl;
  logic [2*DATA_W-1:0] sel_data;

  always_comb begin
    grant_ld  = ld_valid && (!fpu_valid || !favour_fpu);
    grant_fpu = fpu_valid && !grant_ld;
    ld_ready  = (state == IDLE) && !reset && grant_ld;
    fpu_ready = (state == IDLE) && !reset && grant_fpu;
    accept    = ld_ready || fpu_ready;
    sel_addr  = grant_ld ? ld_addr : fpu_addr;
    sel_dbl   = grant_ld ? ld_dbl  : fpu_dbl;
    sel_data  = grant_ld ? ld_data : fpu_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      regWr      <= 1'b0;
      Rw         <= '0;
      busW       <= '0;
      busy       <= 1'b0;
      favour_fpu <= 1'b0;
      pend_lo    <= '0;
      pend_pair  <= '0;
      pend_dbl   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= WR_A;
            regWr      <= 1'b1;
            busy       <= 1'b1;
            favour_fpu <= grant_ld;
            pend_dbl   <= sel_dbl;
            pend_lo    <= sel_data[DATA_W-1:0];
            pend_pair  <= sel_addr[ADDR_W-1:1];
            if (sel_dbl) begin
              // Doubles always start on the even register, whatever addr[0] says.
              Rw   <= {sel_addr[ADDR_W-1:1], 1'b0};
              busW <= sel_data[2*DATA_W-1:DATA_W];
            end else begin
              Rw   <= sel_addr;
              busW <= sel_data[DATA_W-1:0];
            end
          end
        end
        WR_A: begin
          if (pend_dbl) begin
            state <= WR_B;
            Rw    <= {pend_pair, 1'b1};
            busW  <= pend_lo;
          end else begin
            // Rw/busW deliberately hold their last values when idle.
            state <= IDLE;
            regWr <= 1'b0;
            busy  <= 1'b0;
          end
        end
        WR_B: begin
          state <= IDLE;
          regWr <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          regWr <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpr_wr_arbiter.sv
// tb/tb_fpr_wr_arbiter.sv - self-checking bench for fpr_wr_arbiter
module tb_fpr_wr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_valid, ld_ready, ld_dbl;
  logic [4:0]  ld_addr;
  logic [63:0] ld_data;
  logic        fpu_valid, fpu_ready, fpu_dbl;
  logic [4:0]  fpu_addr;
  logic [63:0] fpu_data;
  logic        regWr, busy;
  logic [4:0]  Rw;
  logic [31:0] busW;

  always #5 clk = ~clk;

  fpr_wr_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_dbl(ld_dbl), .ld_data(ld_data),
    .fpu_valid(fpu_valid), .fpu_ready(fpu_ready), .fpu_addr(fpu_addr), .fpu_dbl(fpu_dbl), .fpu_data(fpu_data),
    .regWr(regWr), .Rw(Rw), .busW(busW), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of register writes still owed to the file.
  // The head is the write that must be on the bus this cycle.
  typedef struct packed {
    logic [4:0]  rw;
    logic [31:0] busw;
  } wr_t;

  wr_t         owed[$];
  logic        last_was_fpu;   // reset behaves as if fpu was granted last
  logic [4:0]  last_rw;
  logic [31:0] last_busw;
  logic        acc_ld, acc_fpu;
  logic        dut_ld_ready, dut_fpu_ready;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic owe(input logic [4:0] a, input logic d, input logic [63:0] data);
    wr_t w;
    if (d) begin
      w.rw = {a[4:1], 1'b0}; w.busw = data[63:32]; owed.push_back(w);
      w.rw = {a[4:1], 1'b1}; w.busw = data[31:0];  owed.push_back(w);
    end else begin
      w.rw = a; w.busw = data[31:0]; owed.push_back(w);
    end
  endtask

  // Called just after a negedge with inputs already set; returns at the next negedge.
  task automatic cycle();
    logic idle, pick_ld;
    #1;
    idle    = (owed.size() == 0) && !reset;
    pick_ld = ld_valid && (!fpu_valid || last_was_fpu);
    acc_ld  = idle && pick_ld;
    acc_fpu = idle && fpu_valid && !pick_ld;
    dut_ld_ready  = ld_ready;
    dut_fpu_ready = fpu_ready;
    chk("ld_ready", ld_ready, acc_ld);
    chk("fpu_ready", fpu_ready, acc_fpu);
    @(posedge clk);
    if (reset) begin
      owed.delete();
      last_was_fpu = 1'b1;
      last_rw      = '0;
      last_busw    = '0;
    end else begin
      if (owed.size() > 0) void'(owed.pop_front());
      if (acc_ld) begin
        owe(ld_addr, ld_dbl, ld_data);
        last_was_fpu = 1'b0;
      end
      if (acc_fpu) begin
        owe(fpu_addr, fpu_dbl, fpu_data);
        last_was_fpu = 1'b1;
      end
      if (owed.size() > 0) begin
        last_rw   = owed[0].rw;
        last_busw = owed[0].busw;
      end
    end
    @(negedge clk);
    chk("regWr", regWr, owed.size() != 0);
    chk("busy", busy, owed.size() != 0);
    chk("Rw", Rw, last_rw);
    chk("busW", busW, last_busw);
  endtask

  int  ord[3];
  int  n_acc;
  logic ld_hold, fpu_hold;

  initial begin
    reset = 1'b1;
    ld_valid = 0; ld_addr = 0; ld_dbl = 0; ld_data = 0;
    fpu_valid = 0; fpu_addr = 0; fpu_dbl = 0; fpu_data = 0;
    last_was_fpu = 1'b1; last_rw = '0; last_busw = '0;
    @(negedge clk);

    // Reset state; a held request gets no ready while reset is high.
    ld_valid = 1; ld_addr = 5; ld_dbl = 0; ld_data = 64'h0000_0000_3F80_0000;
    cycle();
    chk("rst_ld_ready", dut_ld_ready, 0);
    cycle();
    chk("rst_regWr", regWr, 0);
    chk("rst_Rw", Rw, 0);
    chk("rst_busW", busW, 0);
    chk("rst_busy", busy, 0);

    // Single write to register 5.
    reset = 0;
    cycle();
    chk("t1_ready", dut_ld_ready, 1);
    chk("t1_regWr", regWr, 1);
    chk("t1_Rw", Rw, 5);
    chk("t1_busW", busW, 32'h3F80_0000);
    chk("t1_busy", busy, 1);
    ld_valid = 0;
    cycle();
    chk("t1_end_regWr", regWr, 0);
    chk("t1_end_busy", busy, 0);
    chk("t1_hold_Rw", Rw, 5);

    // Double to pair 6/7, with ld waiting behind it.
    fpu_valid = 1; fpu_addr = 6; fpu_dbl = 1; fpu_data = 64'h4000_0000_1234_5678;
    cycle();
    chk("t2_ready", dut_fpu_ready, 1);
    chk("t2_Rw_a", Rw, 6);
    chk("t2_busW_a", busW, 32'h4000_0000);
    fpu_valid = 0;
    ld_valid = 1; ld_addr = 3; ld_dbl = 0; ld_data = 64'h0000_0000_AAAA_5555;
    cycle();
    chk("t2_wait_a", dut_ld_ready, 0);
    chk("t2_regWr_b", regWr, 1);
    chk("t2_Rw_b", Rw, 7);
    chk("t2_busW_b", busW, 32'h1234_5678);
    cycle();
    chk("t2_wait_b", dut_ld_ready, 0);
    chk("t2_idle", regWr, 0);
    cycle();
    chk("t2_ld_after", dut_ld_ready, 1);
    chk("t2_ld_Rw", Rw, 3);
    ld_valid = 0;
    cycle();

    // Double with odd address 9 writes 8 then 9.
    fpu_valid = 1; fpu_addr = 9; fpu_dbl = 1; fpu_data = 64'hDEAD_BEEF_CAFE_F00D;
    cycle();
    fpu_valid = 0;
    chk("t3_Rw_a", Rw, 8);
    chk("t3_busW_a", busW, 32'hDEAD_BEEF);
    cycle();
    chk("t3_Rw_b", Rw, 9);
    chk("t3_busW_b", busW, 32'hCAFE_F00D);
    cycle();

    // Both requesters held: ld, fpu, ld.
    reset = 1;
    cycle();
    reset = 0;
    n_acc = 0;
    ord[0] = -1; ord[1] = -1; ord[2] = -1;
    ld_valid = 1; ld_dbl = 0; fpu_valid = 1; fpu_dbl = 0;
    for (int i = 0; i < 12; i++) begin
      ld_addr = 5'(i); ld_data = 64'(32'h1000 + i);
      fpu_addr = 5'(31 - i); fpu_data = 64'(32'h2000 + i);
      cycle();
      if (dut_ld_ready && n_acc < 3) begin ord[n_acc] = 0; n_acc++; end
      if (dut_fpu_ready && n_acc < 3) begin ord[n_acc] = 1; n_acc++; end
    end
    chk("t4_first", ord[0], 0);
    chk("t4_second", ord[1], 1);
    chk("t4_third", ord[2], 0);
    ld_valid = 0; fpu_valid = 0;
    cycle(); cycle();

    // Reset during the first half of a double to register 10.
    ld_valid = 1; ld_addr = 10; ld_dbl = 1; ld_data = 64'h1111_1111_2222_2222;
    cycle();
    ld_valid = 0;
    chk("t5_Rw_a", Rw, 10);
    reset = 1;
    cycle();
    chk("t5_regWr", regWr, 0);
    chk("t5_busy", busy, 0);
    reset = 0;
    cycle();
    chk("t5_no_odd", regWr, 0);
    ld_valid = 1; ld_addr = 1; ld_dbl = 0; fpu_valid = 1; fpu_addr = 2; fpu_dbl = 0;
    cycle();
    chk("t5_ld_first", dut_ld_ready, 1);
    chk("t5_fpu_wait", dut_fpu_ready, 0);
    ld_valid = 0; fpu_valid = 0;
    cycle(); cycle();

    // ld pulsed while busy and dropped: never serviced. Also exercises register 0.
    fpu_valid = 1; fpu_addr = 0; fpu_dbl = 0; fpu_data = 64'h0000_0000_0BAD_CAFE;
    cycle();
    fpu_valid = 0;
    chk("t6_Rw0", Rw, 0);
    ld_valid = 1; ld_addr = 20; ld_dbl = 0; ld_data = 64'h0000_0000_5555_5555;
    cycle();
    chk("t6_pulse", dut_ld_ready, 0);
    ld_valid = 0;
    cycle();
    chk("t6_no_write", regWr, 0);
    cycle();
    chk("t6_busW", busW, 32'h0BAD_CAFE);

    // Randomised traffic with held requests, occasional drops and resets.
    ld_hold = 0; fpu_hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (acc_ld) ld_hold = 0;
      if (acc_fpu) fpu_hold = 0;
      if (ld_hold && $urandom_range(0, 31) == 0) ld_hold = 0;
      if (fpu_hold && $urandom_range(0, 31) == 0) fpu_hold = 0;
      if (!ld_hold && $urandom_range(0, 9) < 5) begin
        ld_hold = 1; ld_addr = 5'($urandom); ld_dbl = 1'($urandom);
        ld_data = {$urandom, $urandom};
      end
      if (!fpu_hold && $urandom_range(0, 9) < 5) begin
        fpu_hold = 1; fpu_addr = 5'($urandom); fpu_dbl = 1'($urandom);
        fpu_data = {$urandom, $urandom};
      end
      ld_valid  = ld_hold;
      fpu_valid = fpu_hold;
      reset = ($urandom_range(0, 63) == 0);
      cycle();
    end
    reset = 0; ld_valid = 0; fpu_valid = 0;
    cycle(); cycle(); cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpr_wr_arbiter.md
Name: fpr_wr_arbiter

Overview:
- Owns the single write port of the floating-point register file.
- Arbitrates between two requesters, the load-return path (ld) and the multi-cycle FPU result path (fpu), using round-robin.
- Sequences double-precision results into two 32-bit writes to an even/odd register pair.
- Drives the file's regWr/Rw/busW from flops, so all three are stable before the file's negedge write.

Parameters:
- DATA_W, 32, width of one FPR and of busW.
- ADDR_W, 5, FPR index width (32 registers).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  reset, synchronous, active-high.
- ld_valid  in  1  load requester has a write pending.
- ld_ready  out  1  ld request accepted this cycle.
- ld_addr  in  ADDR_W  target FPR for ld.
- ld_dbl  in  1  1 = double-precision (64-bit) write.
- ld_data  in  2*DATA_W  write data; the single-precision payload is in the low DATA_W bits.
- fpu_valid  in  1  FPU requester has a write pending.
- fpu_ready  out  1  fpu request accepted this cycle.
- fpu_addr  in  ADDR_W  target FPR for fpu.
- fpu_dbl  in  1  1 = double-precision write.
- fpu_data  in  2*DATA_W  write data; same layout as ld_data.
- regWr  out  1  register-file write enable.
- Rw  out  ADDR_W  register-file write index.
- busW  out  DATA_W  register-file write data.
- busy  out  1  a write sequence is in progress.

Behaviour:
- Reset values:
  - State = IDLE.
  - regWr = 0, Rw = 0, busW = 0, busy = 0.
  - Round-robin pointer favours ld.
  - ld_ready = fpu_ready = 0 while reset is high.
- States:
  - IDLE: no write in progress.
  - WR_A: first (or only) word being written.
  - WR_B: second word of a double being written.
- Handshake:
  - Valid/ready. A requester holds valid, addr, dbl and data stable until it sees its ready high.
  - Acceptance occurs at the posedge where valid && ready.
  - Ready is asserted only when state == IDLE, reset == 0 and that requester is granted; it is never asserted without its valid.
  - ld_ready and fpu_ready are combinational from state, pointer and valids.
  - ld_ready and fpu_ready are never both high.
- Arbitration:
  - Only one valid: that requester is granted.
  - Both valid: the requester not granted last is chosen.
  - The pointer updates only on acceptance.
- Accept, IDLE -> WR_A, at the accept edge:
  - Capture the request; register regWr = 1.
  - Single: Rw = addr, busW = data[DATA_W-1:0].
  - Double: Rw = {addr[ADDR_W-1:1],1'b0}, busW = data[2*DATA_W-1:DATA_W].
- WR_A -> IDLE if single. At the edge, regWr = 0; Rw and busW hold their values.
- WR_A -> WR_B if double. At the edge:
  - Rw = {addr[ADDR_W-1:1],1'b1}.
  - busW = data[DATA_W-1:0].
  - regWr stays 1.
- WR_B -> IDLE unconditionally; regWr = 0.
- Double with an odd addr: addr bit 0 is ignored and the pair is still written even-then-odd. No wrap-around to register 0 occurs.
- busy = (state != IDLE), registered together with state.
- Latency and throughput:
  - First write is visible to the register file in the cycle after acceptance.
  - Single: 2 cycles per request, accept to next possible accept.
  - Double: 3 cycles per request.
- A request arriving while busy waits; its valid must stay held.
- A requester that drops valid before acceptance is simply not serviced; no error is flagged.
- Reset mid-sequence:
  - Any remaining half-write is abandoned; regWr = 0 from the next cycle.
  - The accepted requester is not re-notified.
  - The pointer returns to favouring ld.
- Register 0 is not special; writes to it are issued like any other.

Test Plan:
- Reset, then ld_valid=1, ld_addr=5, ld_dbl=0, ld_data=0x0000_0000_3F80_0000 -> ld_ready=1 in that cycle. Next cycle regWr=1, Rw=5, busW=0x3F80_0000, busy=1. The cycle after, regWr=0, busy=0.
- fpu_valid=1, fpu_addr=6, fpu_dbl=1, fpu_data=0x4000_0000_1234_5678 -> two consecutive regWr cycles: Rw=6/busW=0x4000_0000, then Rw=7/busW=0x1234_5678. ld_ready=fpu_ready=0 during both.
- Double with fpu_addr=9 (odd) -> writes go to Rw=8 then Rw=9.
- ld and fpu both valid and held after reset -> ld granted first, fpu second, then ld again. Grants alternate on every accept; no accept occurs while busy=1.
- Assert reset during WR_A of a double to register 10 -> next cycle regWr=0, busy=0. No write to register 11 occurs. The first post-reset request with both valid grants ld.
- ld_valid pulsed high for one cycle while busy=1, then dropped -> no ld_ready and no write for that request.
